text_buf_writer: RTL and testbench
==================================

# text_buf_writer

Writer side of the text-mode display path: accepts 7-bit character codes over a valid/ready handshake and writes them into the character buffer RAM that the character generator reads each frame. Maintains a cursor over an 80x40 grid of 8x12 cells (640x480), handles a small set of control codes and provides a full-screen clear sequence. It sits between the host/command logic and the write port of the dual-port text RAM, in the clock25 domain.

## Interface
- COLS, 80, characters per row
- ROWS, 40, rows per screen
- ADDR_W, 12, text RAM address width (must satisfy 2^ADDR_W >= COLS*ROWS)

- clock25  input  1  pixel clock; all logic is on its rising edge
- reset_n  input  1  reset: asynchronous, active-low
- char_in  input  7  character code; same 7-bit code space as the font ROM address
- char_valid  input  1  char_in is valid
- char_ready  output  1  block accepts char_in this cycle
- clear  input  1  single-cycle request to blank the screen
- busy  output  1  clear sequence in progress
- wr_en  output  1  text RAM write strobe
- wr_addr  output  ADDR_W  text RAM address, row*COLS + col
- wr_data  output  7  code written to the text RAM
- cursor_col  output  7  current cursor column, 0..COLS-1
- cursor_row  output  6  current cursor row, 0..ROWS-1

## Operation
- States: IDLE, CLEAR.
- char_ready = (state == IDLE) && !clear. This path is combinational. A character is accepted on an edge where char_valid && char_ready.
- Printable codes, 0x20..0x7E:
  - Write the code at the pre-advance cursor.
  - col+1. At COLS-1 the column wraps to 0 and row+1.
  - At ROWS-1 the row wraps to 0. There is no scrolling.
- 0x0A (LF): col=0, row+1 with the same row wrap. No write.
- 0x0D (CR): col=0. No write.
- 0x08 (BS): if col>0, col-1 and write 0x20 at the new position. If col==0, no change and no write.
- All other codes are accepted and dropped. There is no write and no cursor change.
- clear in IDLE:
  - Enter CLEAR and set busy=1.
  - Write 0x20 to addresses 0..COLS*ROWS-1, one per cycle, in ascending order.
  - After the last write, return to IDLE, set busy=0 and set the cursor to (0,0).
- clear while in CLEAR is ignored and does not restart the sequence.
- clear and char_valid in the same IDLE cycle: clear wins and the character is not accepted.

## Timing
- Reset values: char_ready=0 while reset_n is low. On release, state=IDLE, busy=0, wr_en=0, wr_addr=0, wr_data=0, cursor_col=0, cursor_row=0.
- Character write latency: wr_en, wr_addr and wr_data are registered. They assert for exactly one cycle, on the cycle after the accepting edge.
- The cursor updates on the accepting edge. The new cursor value is visible in the same cycle that wr_en is high.
- Throughput: one character per cycle in IDLE.
- Clear:
  - busy rises one cycle after the clear edge.
  - The first write (addr 0) is in that same cycle.
  - The sequence takes COLS*ROWS cycles of wr_en high (3200 for the defaults).
  - busy falls and char_ready rises on the cycle after the last write.
- Reset asserted mid-clear: all outputs go immediately to their reset values and the state goes to IDLE. RAM contents are undefined until the next clear.
- Address arithmetic: wr_addr = row*COLS + col, computed at width ADDR_W with no overflow.

## Configuration
- TEXT_BUF_WRITER_TAB_EN
  - Defined: 0x09 (TAB) moves col to the next multiple of 8 with no write. If the result is >= COLS, col=0 and row+1 with the normal row wrap.
  - Undefined: 0x09 is treated as an unsupported code (accepted and dropped).

## Test plan
- Reset, then send 'A' (0x41) with valid held: accepted on the first edge. Next cycle: wr_en=1, wr_addr=0, wr_data=0x41, cursor=(1,0).
- Send 81 printable characters back-to-back: the 80th writes addr 79 and the cursor goes to (0,1). The 81st writes addr 80. Cursor ends at (1,1).
- Cursor at (5,39), send 0x0A: no write, cursor=(0,0). Send 0x0D at (7,3): cursor=(0,3). Send 0x08 at (7,3): write 0x20 at addr 246, cursor=(6,3). Send 0x08 at (0,3): nothing happens.
- Pulse clear together with char_valid=1: char_ready=0 that cycle. busy=1 for 3200 cycles with addresses 0..3199 and data 0x20. A second clear pulse mid-sequence has no effect. Afterwards cursor=(0,0) and char_ready=1.
- Assert reset_n=0 at write 100 of a clear: wr_en and busy drop immediately. After release the state is IDLE with cursor (0,0).
- With TEXT_BUF_WRITER_TAB_EN defined: 0x09 at col 3 gives col 8, and at col 77 gives (0,row+1). With it undefined: 0x09 leaves the cursor unchanged and there is no write.

Source files
------------

// File: rtl/text_buf_writer.sv
// Text RAM writer: accepts character codes, tracks an 80x40 cursor and runs a full-screen clear.
// Optional TAB handling is enabled by defining TEXT_BUF_WRITER_TAB_EN.
//
// state | meaning
// IDLE  | accepting characters, one per cycle
// CLEAR | writing spaces to every cell, host input stalled
module text_buf_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 40,
    parameter int ADDR_W = 12
) (
    input  logic              clock25,
    input  logic              reset_n,
    input  logic [6:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic              clear,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [6:0]        wr_data,
    output logic [6:0]        cursor_col,
    output logic [5:0]        cursor_row
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
    localparam logic [5:0]        LAST_ROW = 6'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(COLS * ROWS - 1);
    localparam logic [6:0]        SPACE    = 7'h20;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_left, clr_left_nx;
    logic              wr_en_nx;
    logic [ADDR_W-1:0] wr_addr_nx;
    logic [6:0]        wr_data_nx;
    logic [6:0]        col_nx;
    logic [5:0]        row_nx;
    logic [ADDR_W-1:0] cur_addr;
    logic [5:0]        row_adv;

    assign cur_addr   = ADDR_W'(cursor_row) * COLS_A + ADDR_W'(cursor_col);
    assign row_adv    = (cursor_row == LAST_ROW) ? 6'd0 : cursor_row + 6'd1;
    assign char_ready = reset_n && (state == IDLE) && !clear;
    assign busy       = (state == CLEAR);

`ifdef TEXT_BUF_WRITER_TAB_EN
    logic [7:0] tab_col;
    assign tab_col = {1'b0, cursor_col[6:3], 3'b000} + 8'd8;
`endif

    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            clr_left   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
        end else begin
            state      <= state_nx;
            clr_left   <= clr_left_nx;
            wr_en      <= wr_en_nx;
            wr_addr    <= wr_addr_nx;
            wr_data    <= wr_data_nx;
            cursor_col <= col_nx;
            cursor_row <= row_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        clr_left_nx = clr_left;
        wr_en_nx    = 1'b0;
        wr_addr_nx  = wr_addr;
        wr_data_nx  = wr_data;
        col_nx      = cursor_col;
        row_nx      = cursor_row;
        case (state)
            IDLE: begin
                if (clear) begin
                    // First clear write goes out together with busy.
                    state_nx    = CLEAR;
                    clr_left_nx = CLR_LAST;
                    wr_en_nx    = 1'b1;
                    wr_addr_nx  = '0;
                    wr_data_nx  = SPACE;
                end else if (char_valid) begin
                    if (char_in >= 7'h20 && char_in <= 7'h7E) begin
                        wr_en_nx   = 1'b1;
                        wr_addr_nx = cur_addr;
                        wr_data_nx = char_in;
                        if (cursor_col == LAST_COL) begin
                            col_nx = 7'd0;
                            row_nx = row_adv;
                        end else begin
                            col_nx = cursor_col + 7'd1;
                        end
                    end else begin
                        case (char_in)
                            7'h0A: begin
                                col_nx = 7'd0;
                                row_nx = row_adv;
                            end
                            7'h0D: col_nx = 7'd0;
                            7'h08: begin
                                if (cursor_col != 7'd0) begin
                                    col_nx     = cursor_col - 7'd1;
                                    wr_en_nx   = 1'b1;
                                    wr_addr_nx = cur_addr - ADDR_W'(1);
                                    wr_data_nx = SPACE;
                                end
                            end
`ifdef TEXT_BUF_WRITER_TAB_EN
                            7'h09: begin
                                if (tab_col >= 8'(COLS)) begin
                                    col_nx = 7'd0;
                                    row_nx = row_adv;
                                end else begin
                                    col_nx = tab_col[6:0];
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR: begin
                if (clr_left == '0) begin
                    state_nx = IDLE;
                    col_nx   = 7'd0;
                    row_nx   = 6'd0;
                end else begin
                    wr_en_nx    = 1'b1;
                    wr_addr_nx  = wr_addr + ADDR_W'(1);
                    wr_data_nx  = SPACE;
                    clr_left_nx = clr_left - ADDR_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_buf_writer.sv
// Self-checking bench for text_buf_writer: vector table, hand sequences and random codes vs. a cursor model.
module tb_text_buf_writer;

    localparam int COLS   = 80;
    localparam int ROWS   = 40;
    localparam int ADDR_W = 12;

    logic              clock25 = 1'b0;
    logic              reset_n = 1'b0;
    logic [6:0]        char_in = '0;
    logic              char_valid = 1'b0;
    logic              char_ready;
    logic              clear = 1'b0;
    logic              busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [6:0]        wr_data;
    logic [6:0]        cursor_col;
    logic [5:0]        cursor_row;

    int n_checks = 0;
    int n_fail   = 0;
    int m_col    = 0;
    int m_row    = 0;

    text_buf_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clock25    (clock25),
        .reset_n    (reset_n),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .clear      (clear),
        .busy       (busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #5 clock25 = ~clock25;

    typedef struct {
        logic [6:0] ch;
        bit         we;
        int         addr;
        int         data;
        int         col;
        int         row;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: the cursor is a linear cell index on a torus of COLS*ROWS cells.
    task automatic model_apply(input logic [6:0] ch, output bit we, output int addr, output int data);
        int lin;
        we = 0; addr = 0; data = 0;
        if (ch >= 7'h20 && ch <= 7'h7E) begin
            we = 1; addr = m_row * COLS + m_col; data = int'(ch);
            lin = (addr + 1) % (COLS * ROWS);
            m_col = lin % COLS;
            m_row = lin / COLS;
        end else if (ch == 7'h0A) begin
            m_col = 0; m_row = (m_row + 1) % ROWS;
        end else if (ch == 7'h0D) begin
            m_col = 0;
        end else if (ch == 7'h08) begin
            if (m_col > 0) begin
                m_col = m_col - 1;
                we = 1; addr = m_row * COLS + m_col; data = 32;
            end
        end
`ifdef TEXT_BUF_WRITER_TAB_EN
        else if (ch == 7'h09) begin
            if ((m_col / 8 + 1) * 8 >= COLS) begin
                m_col = 0; m_row = (m_row + 1) % ROWS;
            end else begin
                m_col = (m_col / 8 + 1) * 8;
            end
        end
`endif
    endtask

    task automatic send(input logic [6:0] ch);
        bit we; int a; int d;
        char_in = ch;
        char_valid = 1'b1;
        check("char_ready", int'(char_ready), 1);
        model_apply(ch, we, a, d);
        @(posedge clock25); #1;
        char_valid = 1'b0;
        check("wr_en", int'(wr_en), int'(we));
        if (we) begin
            check("wr_addr", int'(wr_addr), a);
            check("wr_data", int'(wr_data), d);
        end
        check("cursor_col", int'(cursor_col), m_col);
        check("cursor_row", int'(cursor_row), m_row);
    endtask

    task automatic idle_cycle();
        char_valid = 1'b0;
        @(posedge clock25); #1;
        check("idle wr_en", int'(wr_en), 0);
        check("idle cursor_col", int'(cursor_col), m_col);
    endtask

    task automatic do_reset();
        char_valid = 1'b0;
        clear = 1'b0;
        reset_n = 1'b0;
        #1;
        check("reset char_ready", int'(char_ready), 0);
        repeat (2) @(posedge clock25);
        @(negedge clock25);
        reset_n = 1'b1;
        #1;
        check("reset busy", int'(busy), 0);
        check("reset wr_en", int'(wr_en), 0);
        check("reset wr_addr", int'(wr_addr), 0);
        check("reset wr_data", int'(wr_data), 0);
        check("reset cursor_col", int'(cursor_col), 0);
        check("reset cursor_row", int'(cursor_row), 0);
        check("post-reset char_ready", int'(char_ready), 1);
        m_col = 0; m_row = 0;
        @(posedge clock25); #1;
    endtask

    task automatic goto_cell(input int col, input int row);
        send(7'h0D);
        while (m_row != row) send(7'h0A);
        for (int i = 0; i < col; i++) send(7'h78);
    endtask

    initial begin
        vec_t tbl[12];
        int   cnt;
        int   bad;
        int   timeout;
        int   r;
        logic [6:0] ch;

        tbl[0]  = '{7'h41, 1, 0,  7'h41, 1, 0};
        tbl[1]  = '{7'h42, 1, 1,  7'h42, 2, 0};
        tbl[2]  = '{7'h0D, 0, 0,  0,     0, 0};
        tbl[3]  = '{7'h0A, 0, 0,  0,     0, 1};
        tbl[4]  = '{7'h43, 1, 80, 7'h43, 1, 1};
        tbl[5]  = '{7'h08, 1, 80, 7'h20, 0, 1};
        tbl[6]  = '{7'h08, 0, 0,  0,     0, 1};
        tbl[7]  = '{7'h01, 0, 0,  0,     0, 1};
        tbl[8]  = '{7'h7F, 0, 0,  0,     0, 1};
        tbl[9]  = '{7'h7E, 1, 80, 7'h7E, 1, 1};
        tbl[10] = '{7'h20, 1, 81, 7'h20, 2, 1};
        tbl[11] = '{7'h1F, 0, 0,  0,     2, 1};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            send(tbl[i].ch);
            check($sformatf("vec%0d wr_en", i), int'(wr_en), int'(tbl[i].we));
            if (tbl[i].we) begin
                check($sformatf("vec%0d wr_addr", i), int'(wr_addr), tbl[i].addr);
                check($sformatf("vec%0d wr_data", i), int'(wr_data), tbl[i].data);
            end
            check($sformatf("vec%0d col", i), int'(cursor_col), tbl[i].col);
            check($sformatf("vec%0d row", i), int'(cursor_row), tbl[i].row);
        end
        idle_cycle();

        // 81 back-to-back printables across the row boundary.
        do_reset();
        for (int i = 0; i < 81; i++) begin
            send(7'h61);
            if (i == 79) begin
                check("row80 wr_addr", int'(wr_addr), 79);
                check("row80 col", int'(cursor_col), 0);
                check("row80 row", int'(cursor_row), 1);
            end
        end
        check("row81 wr_addr", int'(wr_addr), 80);
        check("row81 col", int'(cursor_col), 1);
        check("row81 row", int'(cursor_row), 1);

        // Control codes at the specified cursor positions.
        do_reset();
        goto_cell(5, 39);
        send(7'h0A);
        check("lf wrap wr_en", int'(wr_en), 0);
        check("lf wrap col", int'(cursor_col), 0);
        check("lf wrap row", int'(cursor_row), 0);
        goto_cell(7, 3);
        send(7'h0D);
        check("cr col", int'(cursor_col), 0);
        check("cr row", int'(cursor_row), 3);
        goto_cell(7, 3);
        send(7'h08);
        check("bs wr_en", int'(wr_en), 1);
        check("bs wr_addr", int'(wr_addr), 246);
        check("bs wr_data", int'(wr_data), 32);
        check("bs col", int'(cursor_col), 6);
        send(7'h0D);
        send(7'h08);
        check("bs col0 wr_en", int'(wr_en), 0);
        check("bs col0 col", int'(cursor_col), 0);

        // Tab handling, either build.
        goto_cell(3, 3);
        send(7'h09);
`ifdef TEXT_BUF_WRITER_TAB_EN
        check("tab col3", int'(cursor_col), 8);
`else
        check("tab off col", int'(cursor_col), 3);
`endif
        check("tab wr_en", int'(wr_en), 0);
        goto_cell(77, 3);
        send(7'h09);
`ifdef TEXT_BUF_WRITER_TAB_EN
        check("tab col77 col", int'(cursor_col), 0);
        check("tab col77 row", int'(cursor_row), 4);
`else
        check("tab off col77", int'(cursor_col), 77);
        check("tab off row", int'(cursor_row), 3);
`endif

        // Full clear with simultaneous valid and a redundant mid-sequence clear.
        char_in = 7'h41;
        char_valid = 1'b1;
        clear = 1'b1;
        #1;
        check("clear char_ready", int'(char_ready), 0);
        @(posedge clock25); #1;
        clear = 1'b0;
        char_valid = 1'b0;
        cnt = 0; bad = 0; timeout = 0;
        while (busy && timeout < 3400) begin
            if (!wr_en || int'(wr_addr) != cnt || wr_data != 7'h20) bad++;
            cnt++;
            clear = (cnt == 1000);
            @(posedge clock25); #1;
            timeout++;
        end
        clear = 1'b0;
        check("clear timeout", int'(timeout < 3400), 1);
        check("clear write count", cnt, COLS * ROWS);
        check("clear bad writes", bad, 0);
        check("clear end wr_en", int'(wr_en), 0);
        check("clear end col", int'(cursor_col), 0);
        check("clear end row", int'(cursor_row), 0);
        check("clear end char_ready", int'(char_ready), 1);
        m_col = 0; m_row = 0;

        // Random codes with gaps against the model.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)       ch = 7'($urandom_range(32, 126));
            else if (r == 5) ch = 7'h0A;
            else if (r == 6) ch = 7'h0D;
            else if (r == 7) ch = 7'h08;
            else if (r == 8) ch = 7'h09;
            else             ch = 7'($urandom_range(0, 127));
            send(ch);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        // Reset asserted at the 100th clear write.
        goto_cell(9, 5);
        clear = 1'b1;
        @(posedge clock25); #1;
        clear = 1'b0;
        timeout = 0;
        while (int'(wr_addr) != 100 && timeout < 200) begin
            @(posedge clock25); #1;
            timeout++;
        end
        check("abort reach addr100", int'(timeout < 200), 1);
        check("abort busy before", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("abort wr_en", int'(wr_en), 0);
        check("abort busy", int'(busy), 0);
        check("abort wr_addr", int'(wr_addr), 0);
        check("abort char_ready", int'(char_ready), 0);
        @(negedge clock25);
        reset_n = 1'b1;
        @(posedge clock25); #1;
        check("abort idle busy", int'(busy), 0);
        check("abort idle char_ready", int'(char_ready), 1);
        check("abort col", int'(cursor_col), 0);
        check("abort row", int'(cursor_row), 0);
        m_col = 0; m_row = 0;
        send(7'h5A);
        check("after abort wr_addr", int'(wr_addr), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
